// File: rtl/maxdata_tracker.sv
// Streaming peak detector: scans one frame of valid/ready samples per start command
// and reports the peak value, its first index, the sample count and sticky status flags.
module maxdata_tracker #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int SIGNED     = 0
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [CNT_WIDTH-1:0]  cfg_frame_len,
    input  logic                  cfg_start,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] max_value,
    output logic [CNT_WIDTH-1:0]  max_index,
    output logic [CNT_WIDTH-1:0]  sample_count,
    output logic                  busy,
    output logic                  done,
    output logic                  done_pulse,
    output logic                  err_short,
    output logic                  err_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT                 state_q, state_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic                  done_q, done_d;
    logic                  pulse_q, pulse_d;
    logic                  errShort_q, errShort_d;
    logic                  errZero_q, errZero_d;

    logic                  accept;
    logic                  isGreater;
    logic [CNT_WIDTH-1:0]  cntInc;

    // Ready comes purely from state so it never depends on s_tvalid.
    assign s_tready = (state_q == RUN);
    assign accept   = s_tready && s_tvalid;
    assign cntInc   = cnt_q + CNT_WIDTH'(1);

    always_comb begin
        if (SIGNED != 0) begin
            isGreater = $signed(s_tdata) > $signed(max_q);
        end else begin
            isGreater = s_tdata > max_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        max_d      = max_q;
        done_d     = done_q;
        pulse_d    = 1'b0;
        errShort_d = errShort_q;
        errZero_d  = errZero_q;

        case (state_q)
            IDLE, DONE: begin
                if (cfg_start) begin
                    cnt_d      = '0;
                    idx_d      = '0;
                    max_d      = '0;
                    errShort_d = 1'b0;
                    if (cfg_frame_len != '0) begin
                        state_d   = RUN;
                        len_d     = cfg_frame_len;
                        done_d    = 1'b0;
                        errZero_d = 1'b0;
                    end else begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        pulse_d   = 1'b1;
                        errZero_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_d = cntInc;
                    // The first sample always seeds the peak; later ones must be strictly larger.
                    if ((cnt_q == '0) || isGreater) begin
                        max_d = s_tdata;
                        idx_d = cnt_q;
                    end
                    if (cntInc == len_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pulse_d = 1'b1;
                    end else if (s_tlast) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        pulse_d    = 1'b1;
                        errShort_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            max_q      <= '0;
            done_q     <= 1'b0;
            pulse_q    <= 1'b0;
            errShort_q <= 1'b0;
            errZero_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            max_q      <= max_d;
            done_q     <= done_d;
            pulse_q    <= pulse_d;
            errShort_q <= errShort_d;
            errZero_q  <= errZero_d;
        end
    end

    assign max_value    = max_q;
    assign max_index    = idx_q;
    assign sample_count = cnt_q;
    assign busy         = (state_q == RUN);
    assign done         = done_q;
    assign done_pulse   = pulse_q;
    assign err_short    = errShort_q;
    assign err_zero     = errZero_q;

endmodule

// File: tb/tb_maxdata_tracker.sv
// Directed bench for maxdata_tracker: an unsigned and a signed instance share one stimulus
// stream, and every check compares against a hand-computed value.
module tb_maxdata_tracker;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [15:0] cfgFrameLen = '0;
    logic        cfgStart = 1'b0;
    logic [31:0] sTdata = '0;
    logic        sTvalid = 1'b0;
    logic        sTlast = 1'b0;

    logic        uReady, uBusy, uDone, uPulse, uErrShort, uErrZero;
    logic [31:0] uMax;
    logic [15:0] uIdx, uCnt;
    logic        sReady, sBusy, sDone, sPulse, sErrShort, sErrZero;
    logic [31:0] sMax;
    logic [15:0] sIdx, sCnt;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    maxdata_tracker #(.DATA_WIDTH(32), .CNT_WIDTH(16), .SIGNED(0)) dutU (
        .ACLK(ACLK), .ARESET(ARESET), .cfg_frame_len(cfgFrameLen), .cfg_start(cfgStart),
        .s_tdata(sTdata), .s_tvalid(sTvalid), .s_tlast(sTlast), .s_tready(uReady),
        .max_value(uMax), .max_index(uIdx), .sample_count(uCnt), .busy(uBusy),
        .done(uDone), .done_pulse(uPulse), .err_short(uErrShort), .err_zero(uErrZero)
    );

    maxdata_tracker #(.DATA_WIDTH(32), .CNT_WIDTH(16), .SIGNED(1)) dutS (
        .ACLK(ACLK), .ARESET(ARESET), .cfg_frame_len(cfgFrameLen), .cfg_start(cfgStart),
        .s_tdata(sTdata), .s_tvalid(sTvalid), .s_tlast(sTlast), .s_tready(sReady),
        .max_value(sMax), .max_index(sIdx), .sample_count(sCnt), .busy(sBusy),
        .done(sDone), .done_pulse(sPulse), .err_short(sErrShort), .err_zero(sErrZero)
    );

    task automatic applyStimulus(input logic start, input logic [15:0] len,
                                 input logic valid, input logic [31:0] data, input logic last);
        cfgStart    = start;
        cfgFrameLen = len;
        sTvalid     = valid;
        sTdata      = data;
        sTlast      = last;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset state
        #12;
        checkOutput("rst_ready", {31'd0, uReady}, 32'd0);
        checkOutput("rst_busy", {31'd0, uBusy}, 32'd0);
        checkOutput("rst_done", {31'd0, uDone}, 32'd0);
        checkOutput("rst_max", uMax, 32'd0);
        checkOutput("rst_cnt", {16'd0, uCnt}, 32'd0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        tick();
        checkOutput("idle_ready", {31'd0, uReady}, 32'd0);

        // Unsigned frame 3, 9, 9, 2
        $display("[TB] unsigned frame");
        applyStimulus(1'b1, 16'd4, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("u_start_busy", {31'd0, uBusy}, 32'd1);
        checkOutput("u_start_ready", {31'd0, uReady}, 32'd1);
        applyStimulus(1'b0, 16'd4, 1'b1, 32'd3, 1'b0);
        tick();
        checkOutput("u_s0_max", uMax, 32'd3);
        checkOutput("u_s0_cnt", {16'd0, uCnt}, 32'd1);
        applyStimulus(1'b0, 16'd4, 1'b1, 32'd9, 1'b0);
        tick();
        applyStimulus(1'b0, 16'd4, 1'b1, 32'd9, 1'b0);
        tick();
        checkOutput("u_tie_idx", {16'd0, uIdx}, 32'd1);
        checkOutput("u_s2_cnt", {16'd0, uCnt}, 32'd3);
        checkOutput("u_s2_pulse", {31'd0, uPulse}, 32'd0);
        applyStimulus(1'b0, 16'd4, 1'b1, 32'd2, 1'b0);
        tick();
        checkOutput("u_end_max", uMax, 32'd9);
        checkOutput("u_end_idx", {16'd0, uIdx}, 32'd1);
        checkOutput("u_end_cnt", {16'd0, uCnt}, 32'd4);
        checkOutput("u_end_pulse", {31'd0, uPulse}, 32'd1);
        checkOutput("u_end_done", {31'd0, uDone}, 32'd1);
        checkOutput("u_end_ready", {31'd0, uReady}, 32'd0);
        checkOutput("u_end_busy", {31'd0, uBusy}, 32'd0);
        applyStimulus(1'b0, 16'd4, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("u_post_pulse", {31'd0, uPulse}, 32'd0);
        checkOutput("u_post_done", {31'd0, uDone}, 32'd1);
        checkOutput("u_post_errs", {30'd0, uErrShort, uErrZero}, 32'd0);

        // Signed frames
        $display("[TB] signed frames");
        applyStimulus(1'b1, 16'd3, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'd3, 1'b1, 32'hFFFF_FFFE, 1'b0);
        tick();
        applyStimulus(1'b0, 16'd3, 1'b1, 32'hFFFF_FFFF, 1'b0);
        tick();
        applyStimulus(1'b0, 16'd3, 1'b1, 32'hFFFF_FFF0, 1'b0);
        tick();
        checkOutput("s_neg_max", sMax, 32'hFFFF_FFFF);
        checkOutput("s_neg_idx", {16'd0, sIdx}, 32'd1);
        checkOutput("s_neg_done", {31'd0, sDone}, 32'd1);
        applyStimulus(1'b1, 16'd3, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'd3, 1'b1, 32'd5, 1'b0);
        tick();
        applyStimulus(1'b0, 16'd3, 1'b1, 32'h8000_0000, 1'b0);
        tick();
        applyStimulus(1'b0, 16'd3, 1'b1, 32'h7FFF_FFFF, 1'b0);
        tick();
        checkOutput("s_mix_max", sMax, 32'h7FFF_FFFF);
        checkOutput("s_mix_idx", {16'd0, sIdx}, 32'd2);
        checkOutput("u_mix_max", uMax, 32'h8000_0000);
        checkOutput("u_mix_idx", {16'd0, uIdx}, 32'd1);

        // Short frame with valid gaps, s_tlast on third sample
        $display("[TB] short frame");
        applyStimulus(1'b1, 16'd5, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'd5, 1'b1, 32'd1, 1'b0);
        tick();
        applyStimulus(1'b0, 16'd5, 1'b0, 32'd99, 1'b0);
        tick();
        checkOutput("sh_gap_cnt", {16'd0, uCnt}, 32'd1);
        applyStimulus(1'b0, 16'd5, 1'b1, 32'd7, 1'b0);
        tick();
        applyStimulus(1'b0, 16'd5, 1'b0, 32'd0, 1'b1);
        tick();
        checkOutput("sh_gap2_cnt", {16'd0, uCnt}, 32'd2);
        checkOutput("sh_gap2_busy", {31'd0, uBusy}, 32'd1);
        applyStimulus(1'b0, 16'd5, 1'b1, 32'd4, 1'b1);
        tick();
        checkOutput("sh_max", uMax, 32'd7);
        checkOutput("sh_idx", {16'd0, uIdx}, 32'd1);
        checkOutput("sh_cnt", {16'd0, uCnt}, 32'd3);
        checkOutput("sh_err", {31'd0, uErrShort}, 32'd1);
        checkOutput("sh_done", {31'd0, uDone}, 32'd1);
        checkOutput("sh_pulse", {31'd0, uPulse}, 32'd1);

        // Zero-length start
        $display("[TB] zero length");
        applyStimulus(1'b1, 16'd0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("z_err", {31'd0, uErrZero}, 32'd1);
        checkOutput("z_done", {31'd0, uDone}, 32'd1);
        checkOutput("z_pulse", {31'd0, uPulse}, 32'd1);
        checkOutput("z_ready", {31'd0, uReady}, 32'd0);
        checkOutput("z_cnt", {16'd0, uCnt}, 32'd0);
        checkOutput("z_max", uMax, 32'd0);
        applyStimulus(1'b0, 16'd0, 1'b1, 32'd8, 1'b0);
        tick();
        checkOutput("z_pulse_end", {31'd0, uPulse}, 32'd0);
        checkOutput("z_ready_low", {31'd0, uReady}, 32'd0);

        // Start collision: re-pulse mid-frame is ignored
        $display("[TB] start collision");
        applyStimulus(1'b1, 16'd4, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("c_clr_zero", {31'd0, uErrZero}, 32'd0);
        checkOutput("c_clr_done", {31'd0, uDone}, 32'd0);
        applyStimulus(1'b0, 16'd4, 1'b1, 32'd10, 1'b0);
        tick();
        applyStimulus(1'b1, 16'd2, 1'b1, 32'd20, 1'b0);
        tick();
        checkOutput("c_mid_cnt", {16'd0, uCnt}, 32'd2);
        checkOutput("c_mid_busy", {31'd0, uBusy}, 32'd1);
        applyStimulus(1'b0, 16'd4, 1'b1, 32'd30, 1'b0);
        tick();
        checkOutput("c_s2_cnt", {16'd0, uCnt}, 32'd3);
        applyStimulus(1'b0, 16'd4, 1'b1, 32'd5, 1'b0);
        tick();
        checkOutput("c_end_done", {31'd0, uDone}, 32'd1);
        checkOutput("c_end_max", uMax, 32'd30);
        checkOutput("c_end_idx", {16'd0, uIdx}, 32'd2);
        checkOutput("c_end_cnt", {16'd0, uCnt}, 32'd4);

        // Raise err_short, then a fresh start must clear it
        applyStimulus(1'b1, 16'd4, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'd4, 1'b1, 32'd1, 1'b1);
        tick();
        checkOutput("r_short_set", {31'd0, uErrShort}, 32'd1);
        applyStimulus(1'b1, 16'd4, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("r_short_clr", {31'd0, uErrShort}, 32'd0);
        checkOutput("r_done_clr", {31'd0, uDone}, 32'd0);

        // Async reset mid-frame after two of four samples
        $display("[TB] async reset");
        applyStimulus(1'b0, 16'd4, 1'b1, 32'd6, 1'b0);
        tick();
        applyStimulus(1'b0, 16'd4, 1'b1, 32'd8, 1'b0);
        tick();
        checkOutput("a_pre_cnt", {16'd0, uCnt}, 32'd2);
        #2;
        ARESET = 1'b1;
        #1;
        checkOutput("a_busy", {31'd0, uBusy}, 32'd0);
        checkOutput("a_ready", {31'd0, uReady}, 32'd0);
        checkOutput("a_cnt", {16'd0, uCnt}, 32'd0);
        checkOutput("a_max", uMax, 32'd0);
        checkOutput("a_idx", {16'd0, uIdx}, 32'd0);
        checkOutput("a_flags", {28'd0, uDone, uPulse, uErrShort, uErrZero}, 32'd0);
        tick();
        checkOutput("a_no_pulse", {31'd0, uPulse}, 32'd0);
        ARESET = 1'b0;
        tick();
        checkOutput("a_idle_cnt", {16'd0, uCnt}, 32'd0);
        checkOutput("a_idle_ready", {31'd0, uReady}, 32'd0);

        applyStimulus(1'b0, 16'd0, 1'b0, 32'd0, 1'b0);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
